// File: rtl/cam_pkg.sv
// cam_pkg: shared types and helpers for the LUTRAM CAM write controller.
// Holds LUTRAM geometry, request opcodes, writer FSM states and slice match.
package cam_pkg;

   localparam int LUT_ADDR_W = 6;
   localparam int LUT_DEPTH  = 64;

   typedef enum logic [1:0] {
      CAM_INSERT  = 2'b00,
      CAM_TINSERT = 2'b01,
      CAM_DELETE  = 2'b10,
      CAM_RSVD    = 2'b11
   } cam_op_e;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_SWEEP,
      WR_DONE
   } wr_state_e;

   // Ternary match of one LUTRAM address against a key slice.
   function automatic logic slice_hit(
      input logic [LUT_ADDR_W-1:0] addr,
      input logic [LUT_ADDR_W-1:0] key,
      input logic [LUT_ADDR_W-1:0] mask
   );
      return ((addr ^ key) & ~mask) == '0;
   endfunction

endpackage

// File: rtl/cam_sweep_cnt.sv
// cam_sweep_cnt: W-bit address sweep counter with clear, enable and last flag.
// Ports: clk, rst_n, clr_i, en_i in; cnt_o (count), last_o (count all ones) out.
module cam_sweep_cnt #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = &cnt_q;

endmodule

// File: rtl/cam_lutram_writer.sv
// cam_lutram_writer: sweeps all LUTRAM addresses to (re)write one CAM column.
// Ports: req_valid/req_ready/req_op/req_key/req_mask in; we/waddr/wdata/busy/done out.
module cam_lutram_writer
   import cam_pkg::*;
#(
   parameter int NUM_LUTS = 4,
   parameter int ADDR_W   = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [1:0]                 req_op,
   input  logic [ADDR_W*NUM_LUTS-1:0] req_key,
   input  logic [ADDR_W*NUM_LUTS-1:0] req_mask,
   output logic                       we,
   output logic [ADDR_W-1:0]          waddr,
   output logic [NUM_LUTS-1:0]        wdata,
   output logic                       busy,
   output logic                       done
);

   localparam int KW = ADDR_W * NUM_LUTS;

   wr_state_e             state_q;
   logic [KW-1:0]         key_q;
   logic [KW-1:0]         mask_q;
   cam_op_e               op_q;
   logic                  ready_q;
   logic                  we_q;
   logic [NUM_LUTS-1:0]   wdata_q;
   logic [NUM_LUTS-1:0]   wdata_d;
   logic                  busy_q;
   logic                  done_q;

   logic                  accept;
   logic                  sweeping;
   logic [ADDR_W-1:0]     cnt;
   logic                  cnt_last;

   logic [ADDR_W-1:0]     sel_addr;
   logic [KW-1:0]         sel_key;
   logic [KW-1:0]         sel_mask;
   cam_op_e               sel_op;
   logic                  sel_wr;
   logic                  sel_tern;

   assign accept   = req_valid & ready_q;
   assign sweeping = (state_q == WR_SWEEP);

   cam_sweep_cnt #(
      .W (ADDR_W)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (accept),
      .en_i   (sweeping),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   // wdata is registered, so it is computed one address ahead: address 0
   // from the live request on accept, then cnt+1 from the captured request.
   assign sel_addr = sweeping ? cnt + ADDR_W'(1) : '0;
   assign sel_key  = sweeping ? key_q : req_key;
   assign sel_mask = sweeping ? mask_q : req_mask;
   assign sel_op   = sweeping ? op_q : cam_op_e'(req_op);
   assign sel_wr   = (sel_op == CAM_INSERT) || (sel_op == CAM_TINSERT);
   assign sel_tern = (sel_op == CAM_TINSERT);

   for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
      logic [ADDR_W-1:0] k_i;
      logic [ADDR_W-1:0] m_i;
      assign k_i = sel_key[ADDR_W*i +: ADDR_W];
      assign m_i = sel_tern ? sel_mask[ADDR_W*i +: ADDR_W] : '0;
      assign wdata_d[i] = sel_wr & slice_hit(LUT_ADDR_W'(sel_addr),
                                             LUT_ADDR_W'(k_i),
                                             LUT_ADDR_W'(m_i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WR_IDLE;
         key_q   <= '0;
         mask_q  <= '0;
         op_q    <= CAM_INSERT;
         ready_q <= 1'b1;
         we_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            WR_IDLE: begin
               if (accept) begin
                  state_q <= WR_SWEEP;
                  key_q   <= req_key;
                  mask_q  <= req_mask;
                  op_q    <= cam_op_e'(req_op);
                  ready_q <= 1'b0;
                  we_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  wdata_q <= wdata_d;
               end
            end
            WR_SWEEP: begin
               if (cnt_last) begin
                  state_q <= WR_DONE;
                  we_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  wdata_q <= '0;
               end else begin
                  wdata_q <= wdata_d;
               end
            end
            WR_DONE: begin
               state_q <= WR_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= WR_IDLE;
               ready_q <= 1'b1;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               wdata_q <= '0;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign we        = we_q;
   assign waddr     = cnt;
   assign wdata     = wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_cam_lutram_writer.sv
// tb_cam_lutram_writer: scoreboard bench for the CAM LUTRAM write controller.
// Also rebuilds the match block contents from the writes and checks lookups.
module tb_cam_lutram_writer;
   import cam_pkg::*;

   localparam int NL    = 4;
   localparam int AW    = 6;
   localparam int KW    = NL * AW;
   localparam int DEPTH = LUT_DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [KW-1:0] req_key = '0;
   logic [KW-1:0] req_mask = '0;
   logic          we;
   logic [AW-1:0] waddr;
   logic [NL-1:0] wdata;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   cam_lutram_writer #(
      .NUM_LUTS (NL),
      .ADDR_W   (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_key   (req_key),
      .req_mask  (req_mask),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle-time %0t",
                  name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [AW-1:0] a;
      logic [NL-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   int            acc_log[$];
   int            cyc      = 0;
   int            acc_cyc  = 0;
   int            busy_run = 0;
   bit            done_pend = 0;
   int            cur_op   = 2;
   logic [KW-1:0] cur_key  = '0;
   logic [KW-1:0] cur_mask = '0;
   logic          lut [NL][DEPTH];

   // Expected column bits at LUT address a, from the match rules.
   function automatic logic [NL-1:0] model_col(input int op,
                                               input logic [KW-1:0] key,
                                               input logic [KW-1:0] mask,
                                               input int a);
      logic [NL-1:0] r;
      logic [AW-1:0] av;
      r  = '0;
      av = a[AW-1:0];
      for (int i = 0; i < NL; i++) begin
         logic [AW-1:0] k;
         logic [AW-1:0] m;
         logic          b;
         k = key[AW*i +: AW];
         m = mask[AW*i +: AW];
         b = 1'b0;
         if (op == 0) begin
            b = (av == k);
         end else if (op == 1) begin
            b = 1'b1;
            for (int j = 0; j < AW; j++)
               if (!m[j] && av[j] != k[j]) b = 1'b0;
         end
         r[i] = b;
      end
      return r;
   endfunction

   // Whether the stored entry should match lookup key l.
   function automatic bit model_lookup(input logic [KW-1:0] l);
      if (cur_op == 0) return l == cur_key;
      if (cur_op == 1) begin
         for (int b = 0; b < KW; b++)
            if (!cur_mask[b] && l[b] != cur_key[b]) return 0;
         return 1;
      end
      return 0;
   endfunction

   // Match block: carry-chain AND of each LUT read at its key slice.
   function automatic bit dut_lookup(input logic [KW-1:0] l);
      bit c;
      c = 1;
      for (int i = 0; i < NL; i++) begin
         logic [AW-1:0] s;
         s = l[AW*i +: AW];
         c = c & (lut[i][s] === 1'b1);
      end
      return c;
   endfunction

   // Accept detection and scoreboard push.
   always @(posedge clk) begin
      if (rst_n && req_valid && req_ready) begin
         acc_log.push_back(cyc);
         acc_cyc   = cyc;
         busy_run  = 0;
         done_pend = 1;
         cur_op    = int'(req_op);
         cur_key   = req_key;
         cur_mask  = req_mask;
         for (int a = 0; a < DEPTH; a++) begin
            wr_t e;
            e.a = a[AW-1:0];
            e.d = model_col(cur_op, req_key, req_mask, a);
            exp_q.push_back(e);
         end
      end
      cyc++;
   end

   // Monitor: compares DUT writes and done against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            chk("busy_during_write", busy, 1);
            chk("ready_during_write", req_ready, 0);
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               chk("waddr", waddr, e.a);
               chk("wdata", wdata, e.d);
               for (int i = 0; i < NL; i++) lut[i][waddr] = wdata[i];
            end
         end else begin
            chk("busy_without_write", busy, 0);
         end
         if (busy) busy_run++;
         if (done) begin
            chk("done_expected", done_pend, 1);
            chk("done_writes_left", exp_q.size(), 0);
            chk("done_latency", cyc - acc_cyc, 65);
            chk("busy_length", busy_run, 64);
            chk("ready_in_done", req_ready, 0);
            done_pend = 0;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [KW-1:0] k,
                        input logic [KW-1:0] m);
      int t;
      t = 0;
      while (!req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_issue", req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_key   = k;
      req_mask  = m;
      @(negedge clk);
      req_valid = 1'b0;
      req_key   = KW'($urandom);
      req_mask  = KW'($urandom);
      req_op    = 2'($urandom);
   endtask

   task automatic wait_done;
      int t;
      t = 0;
      while (done !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", done, 1);
      @(negedge clk);
      chk("ready_after_done", req_ready, 1);
   endtask

   task automatic check_lookup(input logic [KW-1:0] l);
      chk("lookup", dut_lookup(l), model_lookup(l));
   endtask

   task automatic lookups_near(input logic [KW-1:0] k);
      logic [KW-1:0] l;
      check_lookup(k);
      for (int b = 0; b < KW; b++) begin
         l = k;
         l[b] = ~l[b];
         check_lookup(l);
      end
      for (int r = 0; r < 8; r++) check_lookup(KW'($urandom));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [KW-1:0] k;
      logic [KW-1:0] l;
      int            n0;
      int            t;

      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // INSERT of the directed key
      issue(2'b00, 24'h0A3F15, KW'($urandom));
      wait_done();
      lookups_near(24'h0A3F15);

      // DELETE clears the column
      issue(2'b10, 24'h0A3F15, '0);
      wait_done();
      check_lookup(24'h0A3F15);
      chk("deleted_miss", dut_lookup(24'h0A3F15), 0);

      // TINSERT key 0, two don't-care bits in slice 0
      issue(2'b01, '0, 24'h000003);
      wait_done();
      for (int s = 0; s < 8; s++) begin
         l = KW'(s);
         check_lookup(l);
      end
      lookups_near('0);

      // TINSERT with every bit don't-care
      issue(2'b01, KW'($urandom), '1);
      wait_done();
      for (int r = 0; r < 8; r++) check_lookup(KW'($urandom));

      // Randomized requests, reserved op included
      for (int r = 0; r < 8; r++) begin
         k = KW'($urandom);
         issue(2'($urandom), k, KW'($urandom & $urandom & $urandom));
         wait_done();
         lookups_near(k);
      end

      // req_valid held high for 190 cycles: accepts at +0, +66, +132
      n0 = acc_log.size();
      req_valid = 1'b1;
      for (int c = 0; c < 190; c++) begin
         req_op   = 2'($urandom);
         req_key  = KW'($urandom);
         req_mask = KW'($urandom);
         @(negedge clk);
      end
      req_valid = 1'b0;
      wait_done();
      chk("held_accepts", acc_log.size() - n0, 3);
      if (acc_log.size() - n0 == 3) begin
         chk("held_gap1", acc_log[n0+1] - acc_log[n0], 66);
         chk("held_gap2", acc_log[n0+2] - acc_log[n0], 132);
      end

      // Reset in the middle of a sweep
      issue(2'b00, KW'($urandom), '0);
      t = 0;
      while (!(we === 1'b1 && waddr == 6'd20) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("reached_addr20", waddr, 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_we", we, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_ready", req_ready, 1);
      exp_q.delete();
      done_pend = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (done === 1'b1) n0++;
      end
      chk("no_done_after_reset", n0, 0);
      chk("ready_after_reset", req_ready, 1);

      // Fresh request after reset sweeps 0..63 again
      k = KW'($urandom);
      issue(2'b00, k, '0);
      wait_done();
      lookups_near(k);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
